// File: rtl/muldiv_pkg.sv
// ---------------------------------------------------------------------------
// muldiv_pkg: op encodings and FSM state constants for muldiv_unit
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package muldiv_pkg;

   localparam logic [1:0] OP_MULTU = 2'b00;
   localparam logic [1:0] OP_MULT  = 2'b01;
   localparam logic [1:0] OP_DIVU  = 2'b10;
   localparam logic [1:0] OP_DIV   = 2'b11;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE = 2'd0;
   localparam state_t ST_RUN  = 2'd1;
   localparam state_t ST_FIX  = 2'd2;

endpackage

`default_nettype wire

// File: rtl/muldiv_signfix.sv
// ---------------------------------------------------------------------------
// muldiv_signfix: operand magnitude extraction and result sign correction
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module muldiv_signfix #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sgn,
   output logic [WIDTH-1:0] a_mag,
   output logic [WIDTH-1:0] b_mag,
   output logic             a_neg,
   output logic             b_neg,
   input  logic             is_div,
   input  logic             neg_a,
   input  logic             neg_b,
   input  logic [WIDTH-1:0] res_hi,
   input  logic [WIDTH-1:0] res_lo,
   output logic [WIDTH-1:0] fix_hi,
   output logic [WIDTH-1:0] fix_lo
);

   logic [2*WIDTH-1:0] prod;
   logic [2*WIDTH-1:0] prod_neg;

   assign a_neg = sgn & a[WIDTH-1];
   assign b_neg = sgn & b[WIDTH-1];
   assign a_mag = a_neg ? -a : a;
   assign b_mag = b_neg ? -b : b;

   assign prod     = {res_hi, res_lo};
   assign prod_neg = -prod;

   // Quotient sign follows sign mismatch; remainder follows the dividend.
   always_comb begin
      fix_hi = res_hi;
      fix_lo = res_lo;
      if (is_div) begin
         fix_lo = (neg_a ^ neg_b) ? -res_lo : res_lo;
         fix_hi = neg_a ? -res_hi : res_hi;
      end else if (neg_a ^ neg_b) begin
         fix_hi = prod_neg[2*WIDTH-1:WIDTH];
         fix_lo = prod_neg[WIDTH-1:0];
      end
   end

endmodule

`default_nettype wire

// File: rtl/muldiv_unit.sv
// ---------------------------------------------------------------------------
// muldiv_unit: iterative mult/multu/div/divu with HI/LO; divide needs DIVIDER_EN
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             hi_we,
   input  logic             lo_we,
   input  logic [WIDTH-1:0] wdata,
   output logic             busy,
   output logic             done,
   output logic             div0,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int            CW   = $clog2(WIDTH) + 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0] mq_q, mq_d;
   logic [WIDTH-1:0] m_q, m_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;
   logic             sa_q, sa_d;
   logic             sb_q, sb_d;
   logic             done_q, done_d;

   logic             is_sgn_op;
   logic             is_div_op;
   logic             is_div;
   logic             accept;
   logic [WIDTH-1:0] a_mag, b_mag, fix_hi, fix_lo;
   logic             a_neg, b_neg;
   logic [WIDTH:0]   mul_sum;

   assign is_sgn_op = (op == OP_MULT) || (op == OP_DIV);

`ifdef DIVIDER_EN
   logic             div_q, div_d;
   logic             div0_q, div0_d;
   logic [WIDTH:0]   div_shift;
   logic [WIDTH-1:0] div_rem;
   logic             div_ge;

   assign is_div_op = (op == OP_DIVU) || (op == OP_DIV);
   assign is_div    = div_q;
   assign accept    = start;
   assign div0      = div0_q;

   // Restoring step: partial remainder < divisor, so the difference fits WIDTH bits.
   assign div_shift = {acc_q, mq_q[WIDTH-1]};
   assign div_ge    = div_shift >= {1'b0, m_q};
   assign div_rem   = div_shift[WIDTH-1:0] - m_q;
`else
   assign is_div_op = 1'b0;
   assign is_div    = 1'b0;
   assign accept    = start & ~op[1];
   assign div0      = 1'b0;
`endif

   assign mul_sum = {1'b0, acc_q} + (mq_q[0] ? {1'b0, m_q} : '0);

   muldiv_signfix #(.WIDTH(WIDTH)) u_signfix (
      .a      (a),
      .b      (b),
      .sgn    (is_sgn_op),
      .a_mag  (a_mag),
      .b_mag  (b_mag),
      .a_neg  (a_neg),
      .b_neg  (b_neg),
      .is_div (is_div),
      .neg_a  (sa_q),
      .neg_b  (sb_q),
      .res_hi (acc_q),
      .res_lo (mq_q),
      .fix_hi (fix_hi),
      .fix_lo (fix_lo)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      mq_d    = mq_q;
      m_d     = m_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      sa_d    = sa_q;
      sb_d    = sb_q;
      done_d  = 1'b0;
`ifdef DIVIDER_EN
      div_d   = div_q;
      div0_d  = 1'b0;
`endif
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               state_d = ST_RUN;
               cnt_d   = '0;
               acc_d   = '0;
               // mq holds the multiplier or the dividend; m the multiplicand or divisor.
               mq_d    = is_div_op ? a_mag : b_mag;
               m_d     = is_div_op ? b_mag : a_mag;
               sa_d    = a_neg;
               sb_d    = b_neg;
`ifdef DIVIDER_EN
               div_d   = is_div_op;
`endif
            end else begin
               if (hi_we) hi_d = wdata;
               if (lo_we) lo_d = wdata;
            end
         end
         ST_RUN: begin
            acc_d = mul_sum[WIDTH:1];
            mq_d  = {mul_sum[0], mq_q[WIDTH-1:1]};
`ifdef DIVIDER_EN
            if (div_q) begin
               acc_d = div_ge ? div_rem : div_shift[WIDTH-1:0];
               mq_d  = {mq_q[WIDTH-2:0], div_ge};
            end
`endif
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST) state_d = ST_FIX;
         end
         ST_FIX: begin
            hi_d    = fix_hi;
            lo_d    = fix_lo;
            done_d  = 1'b1;
            state_d = ST_IDLE;
`ifdef DIVIDER_EN
            // Remainder already equals a after sign fix; only the quotient is forced.
            if (div_q && (m_q == '0)) begin
               lo_d   = '1;
               div0_d = 1'b1;
            end
`endif
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         acc_q   <= '0;
         mq_q    <= '0;
         m_q     <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         sa_q    <= 1'b0;
         sb_q    <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         mq_q    <= mq_d;
         m_q     <= m_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         sa_q    <= sa_d;
         sb_q    <= sb_d;
         done_q  <= done_d;
      end
   end

`ifdef DIVIDER_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_q  <= 1'b0;
         div0_q <= 1'b0;
      end else begin
         div_q  <= div_d;
         div0_q <= div0_d;
      end
   end
`endif

   assign busy = (state_q != ST_IDLE);
   assign done = done_q;
   assign hi   = hi_q;
   assign lo   = lo_q;

endmodule

`default_nettype wire

// File: tb/tb_muldiv_unit.sv
// ---------------------------------------------------------------------------
// tb_muldiv_unit: self-checking bench for muldiv_unit (divide tests need DIVIDER_EN)
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_muldiv_unit;

   localparam int W = 32;

   logic          clk;
   logic          rst_n;
   logic          start;
   logic [1:0]    op;
   logic [W-1:0]  a, b, wdata;
   logic          hi_we, lo_we;
   logic          busy, done, div0;
   logic [W-1:0]  hi, lo;

   int n_checks = 0;
   int n_pass   = 0;

   muldiv_unit #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .op    (op),
      .a     (a),
      .b     (b),
      .hi_we (hi_we),
      .lo_we (lo_we),
      .wdata (wdata),
      .busy  (busy),
      .done  (done),
      .div0  (div0),
      .hi    (hi),
      .lo    (lo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: plain 64-bit arithmetic; returns {hi, lo}.
   function automatic logic [63:0] ref_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
      longint sx, sy, q, r;
      logic [63:0] res;
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      case (o)
         2'b00: res = {32'd0, x} * {32'd0, y};
         2'b01: res = 64'(sx * sy);
         2'b10: begin
            if (y == 0) res = {x, 32'hFFFF_FFFF};
            else        res = {x % y, x / y};
         end
         default: begin
            if (y == 0) res = {x, 32'hFFFF_FFFF};
            else begin
               q = sx / sy;
               r = sx % sy;
               res = {r[31:0], q[31:0]};
            end
         end
      endcase
      return res;
   endfunction

   // Issue one op from an IDLE negedge; returns at the negedge where done is seen.
   task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                         output logic [31:0] rh, output logic [31:0] rl,
                         output int k, output int bcnt, output logic d0);
      logic got;
      start = 1'b1; op = o; a = x; b = y;
      @(posedge clk); #1;
      start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
      a = $urandom; b = $urandom; op = 2'($urandom);
      k = 0; bcnt = 0; got = 1'b0; rh = '0; rl = '0; d0 = 1'b0;
      for (int c = 1; c <= 60 && !got; c++) begin
         @(negedge clk);
         if (busy) bcnt++;
         if (done) begin
            got = 1'b1; k = c; rh = hi; rl = lo; d0 = div0;
            if (busy !== 1'b0) begin
               n_checks++;
               $display("FAIL busy_at_done: got %b want 0", busy);
            end
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start = 1'b0; op = '0; a = '0; b = '0;
      hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
      #1;
      n_checks++;
      if ({busy, done, div0, hi, lo} !== '0)
         $display("FAIL reset_state: got busy=%b done=%b div0=%b hi=%h lo=%h want all 0", busy, done, div0, hi, lo);
      else n_pass++;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_multu_max();
      logic [31:0] rh, rl; int k, bc; logic d0;
      run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, rh, rl, k, bc, d0);
      n_checks++;
      if (k !== 34) $display("FAIL multu_latency: got %0d want 34", k); else n_pass++;
      n_checks++;
      if ({rh, rl} !== 64'hFFFF_FFFE_0000_0001) $display("FAIL multu_max: got %h_%h want fffffffe_00000001", rh, rl);
      else n_pass++;
   endtask

   task automatic test_mult_signed();
      logic [31:0] rh, rl; int k, bc; logic d0;
      run_op(2'b01, -32'sd3, 32'd5, rh, rl, k, bc, d0);
      n_checks++;
      if ({rh, rl} !== 64'hFFFF_FFFF_FFFF_FFF1) $display("FAIL mult_neg: got %h_%h want ffffffff_fffffff1", rh, rl);
      else n_pass++;
      n_checks++;
      if (bc !== 33) $display("FAIL mult_busy_len: got %0d want 33", bc); else n_pass++;
   endtask

`ifdef DIVIDER_EN
   task automatic test_divide();
      logic [31:0] rh, rl; int k, bc; logic d0;
      run_op(2'b11, -32'sd7, 32'd2, rh, rl, k, bc, d0);
      n_checks++;
      if ({rh, rl} !== 64'hFFFF_FFFF_FFFF_FFFD) $display("FAIL div_neg: got %h_%h want ffffffff_fffffffd", rh, rl);
      else n_pass++;
      run_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, rh, rl, k, bc, d0);
      n_checks++;
      if ({rh, rl, d0} !== {64'h0000_0000_8000_0000, 1'b0})
         $display("FAIL div_minneg: got %h_%h div0=%b want 00000000_80000000 div0=0", rh, rl, d0);
      else n_pass++;
   endtask

   task automatic test_divzero();
      logic [31:0] rh, rl; int k, bc; logic d0;
      run_op(2'b10, 32'd100, 32'd0, rh, rl, k, bc, d0);
      n_checks++;
      if ({rh, rl, d0, k} !== {64'h0000_0064_FFFF_FFFF, 1'b1, 32'd34})
         $display("FAIL divu_zero: got %h_%h div0=%b cyc=%0d want 00000064_ffffffff div0=1 cyc=34", rh, rl, d0, k);
      else n_pass++;
      @(negedge clk);
      n_checks++;
      if ({done, div0} !== 2'b00) $display("FAIL div0_pulse: got done=%b div0=%b want 0 0", done, div0);
      else n_pass++;
   endtask
`else
   task automatic test_divide_disabled();
      logic [31:0] h0, l0;
      logic seen;
      h0 = hi; l0 = lo; seen = 1'b0;
      start = 1'b1; op = 2'b10; a = 32'd100; b = 32'd0;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (40) begin
         @(negedge clk);
         if (busy || done || div0) seen = 1'b1;
      end
      n_checks++;
      if (seen !== 1'b0) $display("FAIL div_ignored: got activity=%b want 0", seen); else n_pass++;
      n_checks++;
      if ({hi, lo} !== {h0, l0}) $display("FAIL div_ignored_hilo: got %h_%h want %h_%h", hi, lo, h0, l0);
      else n_pass++;
   endtask
`endif

   task automatic test_abort();
      logic [31:0] rh, rl; int k, bc; logic d0; logic seen;
      hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hA5A5_0001;
      @(posedge clk); #1;
      hi_we = 1'b0; lo_we = 1'b0;
      n_checks++;
      if ({hi, lo} !== {2{32'hA5A5_0001}}) $display("FAIL hilo_both_write: got %h_%h want a5a50001_a5a50001", hi, lo);
      else n_pass++;
      @(negedge clk);
      start = 1'b1; op = 2'b00; a = 32'd1234567; b = 32'd7654321;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (10) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      n_checks++;
      if ({busy, hi, lo} !== '0) $display("FAIL abort_async: got busy=%b hi=%h lo=%h want 0", busy, hi, lo);
      else n_pass++;
      @(negedge clk);
      rst_n = 1'b1;
      seen = 1'b0;
      repeat (40) begin
         @(negedge clk);
         if (done || busy) seen = 1'b1;
      end
      n_checks++;
      if (seen !== 1'b0) $display("FAIL abort_no_done: got activity=%b want 0", seen); else n_pass++;
      run_op(2'b00, 32'd1234567, 32'd7654321, rh, rl, k, bc, d0);
      n_checks++;
      if ({rh, rl, k} !== {ref_op(2'b00, 32'd1234567, 32'd7654321), 32'd34})
         $display("FAIL after_abort: got %h_%h cyc=%0d want %h cyc=34", rh, rl, k, ref_op(2'b00, 32'd1234567, 32'd7654321));
      else n_pass++;
   endtask

   task automatic test_busy_ignore();
      logic [31:0] rh, rl; logic got; logic [63:0] exp;
      exp = ref_op(2'b01, 32'hFFFF_F000, 32'd300);
      start = 1'b1; op = 2'b01; a = 32'hFFFF_F000; b = 32'd300;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (5) @(negedge clk);
      start = 1'b1; op = 2'b00; a = 32'd99; b = 32'd77;
      hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h1234;
      @(negedge clk);
      start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
      got = 1'b0; rh = '0; rl = '0;
      for (int c = 0; c < 60 && !got; c++) begin
         @(negedge clk);
         if (done) begin got = 1'b1; rh = hi; rl = lo; end
      end
      n_checks++;
      if (got !== 1'b1 || {rh, rl} !== exp) $display("FAIL busy_ignore: got done=%b %h_%h want 1 %h", got, rh, rl, exp);
      else n_pass++;
      hi_we = 1'b1; wdata = 32'h1234;
      @(posedge clk); #1;
      hi_we = 1'b0;
      n_checks++;
      if ({hi, lo} !== {32'h1234, exp[31:0]}) $display("FAIL mthi_idle: got %h_%h want 00001234_%h", hi, lo, exp[31:0]);
      else n_pass++;
   endtask

   task automatic test_start_beats_write();
      logic [31:0] rh, rl; int k, bc; logic d0;
      @(negedge clk);
      hi_we = 1'b1; wdata = 32'hDEAD_BEEF;
      run_op(2'b00, 32'h8000_0000, 32'd4, rh, rl, k, bc, d0);
      n_checks++;
      if ({rh, rl} !== 64'h0000_0002_0000_0000) $display("FAIL start_wins: got %h_%h want 00000002_00000000", rh, rl);
      else n_pass++;
   endtask

   task automatic test_back_to_back();
      logic [31:0] rh, rl, x, y; int k, bc; logic d0;
      for (int i = 0; i < 3; i++) begin
         x = $urandom; y = $urandom;
         run_op(2'(i % 2), x, y, rh, rl, k, bc, d0);
         n_checks++;
         if ({rh, rl, k} !== {ref_op(2'(i % 2), x, y), 32'd34})
            $display("FAIL back_to_back[%0d]: got %h_%h cyc=%0d want %h cyc=34", i, rh, rl, k, ref_op(2'(i % 2), x, y));
         else n_pass++;
      end
   endtask

   task automatic test_random();
      logic [31:0] rh, rl, x, y; int k, bc; logic d0; logic [1:0] o; logic [63:0] exp;
      for (int i = 0; i < 24; i++) begin
`ifdef DIVIDER_EN
         o = 2'($urandom_range(0, 3));
`else
         o = 2'($urandom_range(0, 1));
`endif
         x = $urandom; y = $urandom;
         case ($urandom_range(0, 7))
            0: y = 32'd0;
            1: begin x = 32'h8000_0000; y = 32'hFFFF_FFFF; end
            2: y = 32'($urandom_range(1, 9));
            3: x = 32'($urandom_range(0, 300));
            default: ;
         endcase
         exp = ref_op(o, x, y);
         run_op(o, x, y, rh, rl, k, bc, d0);
         n_checks++;
         if ({rh, rl} !== exp || k !== 34 || d0 !== (o[1] && y == 0))
            $display("FAIL random[%0d] op=%0d a=%h b=%h: got %h_%h cyc=%0d div0=%b want %h cyc=34 div0=%b",
                     i, o, x, y, rh, rl, k, d0, exp, (o[1] && y == 0));
         else n_pass++;
      end
   endtask

   initial begin
      test_reset();
      test_multu_max();
      test_mult_signed();
`ifdef DIVIDER_EN
      test_divide();
      test_divzero();
`else
      test_divide_disabled();
`endif
      test_abort();
      test_busy_ignore();
      test_start_beats_write();
      test_back_to_back();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1);
   end

endmodule

`default_nettype wire
